// File: rtl/operand_issue.sv
// Decode/issue stage ahead of the ALU: splits instructions, reads two operands with
// writeback bypass, and stalls on a per-register pending scoreboard.
module operand_issue #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_alu_op,
    output logic [DATA_W-1:0] out_input1,
    output logic [DATA_W-1:0] out_input2,
    output logic [DATA_W-1:0] out_imm,
    output logic [3:0]        out_rd,
    input  logic              wb_en,
    input  logic [3:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              busy
);

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  pending;
    logic [NREGS-1:0]  pending_nxt;

    logic [2:0]        alu_op;
    logic [3:0]        rd;
    logic [3:0]        rs1;
    logic [3:0]        rs2;
    logic [16:0]       imm;
    logic              hit1;
    logic              hit2;
    logic              hazard;
    logic              issue;
    logic [DATA_W-1:0] read1;
    logic [DATA_W-1:0] read2;

    assign alu_op = in_instr[31:29];
    assign rd     = in_instr[28:25];
    assign rs1    = in_instr[24:21];
    assign rs2    = in_instr[20:17];
    assign imm    = in_instr[16:0];

    // A writeback landing this cycle resolves the hazard on that register.
    assign hit1   = pending[rs1] && !(wb_en && wb_addr == rs1);
    assign hit2   = pending[rs2] && !(wb_en && wb_addr == rs2);
    assign hazard = hit1 || hit2;

    assign in_ready = (!out_valid || out_ready) && !hazard;
    assign issue    = in_valid && in_ready;
    assign busy     = |pending;

    always_comb begin
        read1 = '0;
        read2 = '0;
        if (rs1 != 4'd0) begin
            read1 = (wb_en && wb_addr == rs1) ? wb_data : regs[rs1];
        end
        if (rs2 != 4'd0) begin
            read2 = (wb_en && wb_addr == rs2) ? wb_data : regs[rs2];
        end
    end

    // Clear on writeback first so an issue targeting the same register wins.
    always_comb begin
        pending_nxt = pending;
        if (wb_en) begin
            pending_nxt[wb_addr] = 1'b0;
        end
        if (issue && alu_op != 3'b000 && rd != 4'd0) begin
            pending_nxt[rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && wb_addr != 4'd0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_alu_op <= '0;
            out_input1 <= '0;
            out_input2 <= '0;
            out_imm    <= '0;
            out_rd     <= '0;
        end else if (issue) begin
            out_valid  <= 1'b1;
            out_alu_op <= alu_op;
            out_input1 <= read1;
            out_input2 <= read2;
            out_imm    <= {{(DATA_W-17){imm[16]}}, imm};
            out_rd     <= rd;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_issue.sv
// Directed bench for operand_issue: issue, hazard stall with bypass, back-pressure,
// immediate sign extension, r0 handling, NOP scoreboard behaviour and async reset.
module tb_operand_issue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_alu_op;
    logic [31:0] out_input1;
    logic [31:0] out_input2;
    logic [31:0] out_imm;
    logic [3:0]  out_rd;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        busy;

    int checks;
    int errors;

    operand_issue #(.DATA_W(32), .NREGS(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_op(out_alu_op), .out_input1(out_input1), .out_input2(out_input2),
        .out_imm(out_imm), .out_rd(out_rd),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [2:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [3:0] rs2,
                                       input logic [16:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are read before the next.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0h expected 0", out_valid); end
        checks++; if (out_input1 !== 32'h0) begin errors++; $display("[TB] FAIL reset_input1: got %h expected 00000000", out_input1); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0h expected 0", busy); end
        rst_n = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %0h expected 1", in_ready); end
    endtask

    task automatic test_issue();
        wb_en = 1'b1; wb_addr = 4'd3; wb_data = 32'h5;
        tick();
        wb_addr = 4'd4; wb_data = 32'h3;
        tick();
        wb_en = 1'b0;
        in_valid = 1'b1; in_instr = mk(3'b010, 4'd5, 4'd3, 4'd4, 17'd0);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL issue_valid: got %0h expected 1", out_valid); end
        checks++; if (out_input1 !== 32'h5) begin errors++; $display("[TB] FAIL issue_input1: got %h expected 00000005", out_input1); end
        checks++; if (out_input2 !== 32'h3) begin errors++; $display("[TB] FAIL issue_input2: got %h expected 00000003", out_input2); end
        checks++; if (out_rd !== 4'd5) begin errors++; $display("[TB] FAIL issue_rd: got %0d expected 5", out_rd); end
        checks++; if (out_alu_op !== 3'b010) begin errors++; $display("[TB] FAIL issue_op: got %0d expected 2", out_alu_op); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL issue_busy: got %0h expected 1", busy); end
    endtask

    task automatic test_hazard();
        in_valid = 1'b1; in_instr = mk(3'b011, 4'd6, 4'd5, 4'd0, 17'd0);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL hazard_stall: got %0h expected 0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL hazard_drain: got %0h expected 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL hazard_stall2: got %0h expected 0", in_ready); end
        wb_en = 1'b1; wb_addr = 4'd5; wb_data = 32'h8;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL hazard_wb_ready: got %0h expected 1", in_ready); end
        tick();
        wb_en = 1'b0; in_valid = 1'b0;
        checks++; if (out_input1 !== 32'h8) begin errors++; $display("[TB] FAIL hazard_bypass: got %h expected 00000008", out_input1); end
        checks++; if (out_rd !== 4'd6) begin errors++; $display("[TB] FAIL hazard_rd: got %0d expected 6", out_rd); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL hazard_busy6: got %0h expected 1", busy); end
        wb_en = 1'b1; wb_addr = 4'd6; wb_data = 32'h10;
        tick();
        wb_en = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL hazard_clear: got %0h expected 0", busy); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = mk(3'b001, 4'd0, 4'd3, 4'd4, 17'h01234);
        tick();
        in_instr = mk(3'b001, 4'd0, 4'd0, 4'd0, 17'd0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid[%0d]: got %0h expected 1", i, out_valid); end
            checks++; if (out_input1 !== 32'h5) begin errors++; $display("[TB] FAIL bp_input1[%0d]: got %h expected 00000005", i, out_input1); end
            checks++; if (out_imm !== 32'h0000_1234) begin errors++; $display("[TB] FAIL bp_imm[%0d]: got %h expected 00001234", i, out_imm); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready[%0d]: got %0h expected 0", i, in_ready); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release: got %0h expected 1", in_ready); end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain: got %0h expected 0", out_valid); end
    endtask

    task automatic test_imm();
        in_valid = 1'b1; in_instr = mk(3'b110, 4'd0, 4'd0, 4'd0, 17'h1FFFF);
        tick();
        checks++; if (out_imm !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL imm_neg: got %h expected ffffffff", out_imm); end
        checks++; if (out_alu_op !== 3'b110) begin errors++; $display("[TB] FAIL imm_op: got %0d expected 6", out_alu_op); end
        in_instr = mk(3'b110, 4'd0, 4'd0, 4'd0, 17'h0FFFF);
        tick();
        in_valid = 1'b0;
        checks++; if (out_imm !== 32'h0000_FFFF) begin errors++; $display("[TB] FAIL imm_pos: got %h expected 0000ffff", out_imm); end
        tick();
    endtask

    task automatic test_r0();
        wb_en = 1'b1; wb_addr = 4'd0; wb_data = 32'hDEAD_BEEF;
        in_valid = 1'b1; in_instr = mk(3'b010, 4'd0, 4'd0, 4'd3, 17'd0);
        tick();
        wb_en = 1'b0;
        checks++; if (out_input1 !== 32'h0) begin errors++; $display("[TB] FAIL r0_bypass: got %h expected 00000000", out_input1); end
        checks++; if (out_input2 !== 32'h5) begin errors++; $display("[TB] FAIL r0_input2: got %h expected 00000005", out_input2); end
        tick();
        checks++; if (out_input1 !== 32'h0) begin errors++; $display("[TB] FAIL r0_stored: got %h expected 00000000", out_input1); end
        in_instr = mk(3'b000, 4'd7, 4'd0, 4'd0, 17'd0);
        tick();
        in_instr = mk(3'b010, 4'd0, 4'd7, 4'd0, 17'd0);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL nop_busy: got %0h expected 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL nop_no_stall: got %0h expected 1", in_ready); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = mk(3'b010, 4'd5, 4'd3, 4'd4, 17'd0);
        tick();
        in_instr = mk(3'b011, 4'd6, 4'd5, 4'd0, 17'd0);
        #1;
        checks++; if (busy !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_setup: got busy=%0h valid=%0h expected 1/1", busy, out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_stall: got %0h expected 0", in_ready); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid: got %0h expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy: got %0h expected 0", busy); end
        checks++; if (out_input1 !== 32'h0) begin errors++; $display("[TB] FAIL mid_data: got %h expected 00000000", out_input1); end
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_instr = mk(3'b010, 4'd0, 4'd3, 4'd0, 17'd0);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL post_valid: got %0h expected 1", out_valid); end
        checks++; if (out_input1 !== 32'h0) begin errors++; $display("[TB] FAIL post_r3: got %h expected 00000000", out_input1); end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_issue();
        test_hazard();
        test_backpressure();
        test_imm();
        test_r0();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
